// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises valid/ready bitstream words MSB-first onto a ccff chain,
// with an optional recirculating verify pass against a shadow copy of the loaded image.
module ccff_chain_loader #(
  parameter int  CHAIN_LEN = 36,
  parameter int  WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam int AW = (CNT_W > BW) ? CNT_W : BW;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WORD_W-1:0]     r_buf;
  logic [BW-1:0]         r_buf_cnt;
  logic [AW-1:0]         r_acc;
  logic [CHAIN_LEN-1:0]  r_shadow;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_verify;
  logic                  r_err;

  logic                  w_load_shift;
  logic                  w_last;
  logic                  w_accept;
  logic [AW-1:0]         w_remain;
  logic [AW-1:0]         w_take;

  // The final word only contributes the bits still missing from the chain; its surplus LSBs never shift.
  assign w_remain     = AW'(CHAIN_LEN) - r_acc;
  assign w_take       = (w_remain > AW'(WORD_W)) ? AW'(WORD_W) : w_remain;
  assign w_load_shift = (r_state == S_LOAD) && (r_buf_cnt != '0);
  assign w_last       = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_accept     = cfg_valid && cfg_ready;
  assign bit_count    = r_bit_cnt;
  assign cfg_err      = r_err;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    cfg_ready     = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        busy      = 1'b1;
        cfg_ready = (r_buf_cnt <= BW'(1)) && (r_acc < AW'(CHAIN_LEN));
        if (w_load_shift) begin
          ccff_shift_en = 1'b1;
          ccff_head     = r_buf[WORD_W-1];
          if (w_last) begin
            w_state_nxt = r_verify ? S_VERIFY : S_DONE;
          end
        end
      end
      S_VERIFY: begin
        busy          = 1'b1;
        ccff_shift_en = 1'b1;
        ccff_head     = ccff_tail;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_buf     <= '0;
      r_buf_cnt <= '0;
      r_acc     <= '0;
      r_shadow  <= '0;
      r_bit_cnt <= '0;
      r_verify  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_verify  <= verify_en;
        r_err     <= 1'b0;
        r_bit_cnt <= '0;
        r_acc     <= '0;
        r_buf_cnt <= '0;
      end
      if (ccff_shift_en) begin
        if (w_last) begin
          r_bit_cnt <= ((r_state == S_LOAD) && r_verify) ? '0 : CNT_W'(CHAIN_LEN);
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
      if (w_load_shift) begin
        r_shadow <= {r_shadow[CHAIN_LEN-2:0], r_buf[WORD_W-1]};
      end
      // Rotating the shadow keeps it aligned with the recirculating chain.
      if (r_state == S_VERIFY) begin
        r_shadow <= {r_shadow[CHAIN_LEN-2:0], r_shadow[CHAIN_LEN-1]};
        if (ccff_tail != r_shadow[CHAIN_LEN-1]) begin
          r_err <= 1'b1;
        end
      end
      if (w_accept) begin
        r_buf     <= cfg_data;
        r_buf_cnt <= w_take[BW-1:0];
        r_acc     <= r_acc + w_take;
      end else if (w_load_shift) begin
        r_buf     <= r_buf << 1;
        r_buf_cnt <= r_buf_cnt - BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: chain environment, per-cycle behavioural model, directed and random loads.
module tb_ccff_chain_loader;
  localparam int L  = 36;
  localparam int WA = 8;
  localparam int WB = 32;
  localparam int CW = $clog2(L + 1);

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;

  logic a_start = 0, a_ver = 0, a_valid = 0;
  logic [WA-1:0] a_data = '0;
  logic a_ready, a_head, a_shift, a_tail, a_busy, a_done, a_err;
  logic [CW-1:0] a_bc;

  logic b_start = 0, b_ver = 0, b_valid = 0;
  logic [WB-1:0] b_data = '0;
  logic b_ready, b_head, b_shift, b_tail, b_busy, b_done, b_err;
  logic [CW-1:0] b_bc;

  logic [L-1:0] chain_a = '0;
  logic [L-1:0] chain_b = '0;
  assign a_tail = chain_a[L-1];
  assign b_tail = chain_b[L-1];

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(WA)) u_dut_a (
    .prog_clk(prog_clk), .pReset(pReset), .start(a_start), .verify_en(a_ver),
    .cfg_data(a_data), .cfg_valid(a_valid), .cfg_ready(a_ready), .ccff_head(a_head),
    .ccff_shift_en(a_shift), .ccff_tail(a_tail), .busy(a_busy), .done(a_done),
    .cfg_err(a_err), .bit_count(a_bc));

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(WB)) u_dut_b (
    .prog_clk(prog_clk), .pReset(pReset), .start(b_start), .verify_en(b_ver),
    .cfg_data(b_data), .cfg_valid(b_valid), .cfg_ready(b_ready), .ccff_head(b_head),
    .ccff_shift_en(b_shift), .ccff_tail(b_tail), .busy(b_busy), .done(b_done),
    .cfg_err(b_err), .bit_count(b_bc));

  always #5 prog_clk = ~prog_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Chain environment: a plain shift register advancing when shift_en is high.
  logic flip_now = 1'b0;
  int   b_sh_cnt = 0;
  always @(posedge prog_clk) begin : chain_env
    logic [L-1:0] nx;
    if (a_shift) begin
      nx = {chain_a[L-2:0], a_head};
      if (flip_now) nx[17] = ~nx[17];
      chain_a <= nx;
    end
    if (b_shift) begin
      chain_b <= {chain_b[L-2:0], b_head};
      b_sh_cnt = b_sh_cnt + 1;
    end
  end

  // Behavioural model of DUT A: sequence phase, bits accepted, bits shifted, loaded image.
  bit m_in_seq = 0, m_ver = 0, m_err = 0, flip_req = 0;
  int m_shifts = 0, m_acc = 0;
  bit img[$];
  int a_sh_cnt = 0, a_low_cnt = 0, a_done_cnt = 0;

  always @(negedge prog_clk) begin : model
    int total, exp_bc, take;
    bit exp_busy, exp_done, exp_sh, exp_rdy, was_idle;
    if (pReset) begin
      m_in_seq = 0; m_ver = 0; m_err = 0; m_shifts = 0; m_acc = 0; flip_now = 0;
      img.delete();
    end else begin
      total    = m_ver ? 2 * L : L;
      exp_busy = m_in_seq && (m_shifts < total);
      exp_done = m_in_seq && (m_shifts == total);
      exp_sh   = exp_busy && ((m_shifts >= L) || (m_acc > m_shifts));
      exp_rdy  = exp_busy && (m_shifts < L) && (m_acc < L) && (m_acc - m_shifts <= 1);
      exp_bc   = (m_ver && m_shifts >= L) ? m_shifts - L : m_shifts;
      chk("busy", a_busy, exp_busy);
      chk("done", a_done, exp_done);
      chk("shift_en", a_shift, exp_sh);
      chk("cfg_ready", a_ready, exp_rdy);
      chk("cfg_err", a_err, m_err);
      chk("bit_count", a_bc, exp_bc);
      if (exp_sh && m_shifts < L) chk("head_load", a_head, img[m_shifts]);
      if (exp_sh && m_shifts >= L) chk("head_recirc", a_head, a_tail);
      if (a_shift) a_sh_cnt++;
      if (a_busy && !a_shift) a_low_cnt++;
      if (a_done) a_done_cnt++;

      was_idle = !m_in_seq;
      if (exp_done) m_in_seq = 0;
      if (was_idle && a_start) begin
        m_in_seq = 1; m_ver = a_ver; m_shifts = 0; m_acc = 0; m_err = 0;
        img.delete();
      end
      if (exp_rdy && a_valid) begin
        take = (L - m_acc < WA) ? L - m_acc : WA;
        for (int b = 0; b < take; b++) img.push_back(a_data[WA-1-b]);
        m_acc += take;
      end
      if (exp_sh && m_shifts >= L && (a_tail != img[m_shifts-L])) m_err = 1;
      if (exp_sh) m_shifts++;
      flip_now = flip_req && exp_sh && (m_shifts == L);
    end
  end

  logic [WA-1:0] words_a[5];

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic start_a(input bit v);
    a_start = 1; a_ver = v;
    tick();
    a_start = 0;
  endtask

  task automatic send_a(input int stall_at, input int stall_len);
    int g, k;
    for (int i = 0; i < 5; i++) begin
      if (pReset) break;
      if (i == stall_at) begin
        k = 0; g = 0; a_valid = 0;
        while (k < stall_len && g < 200 && !pReset) begin
          if (a_ready) k++;
          tick(); g++;
        end
      end
      a_data = words_a[i]; a_valid = 1; g = 0;
      while (!a_ready && g < 200 && !pReset) begin tick(); g++; end
      chk("send_timeout", (g >= 200), 0);
      if (pReset) break;
      tick();
    end
    a_valid = 0;
  endtask

  task automatic wait_done_a();
    int g = 0;
    while (!a_done && g < 300) begin tick(); g++; end
    chk("done_timeout", (g >= 300), 0);
    tick();
  endtask

  task automatic run_a(input bit v, input int stall_at, input int stall_len);
    start_a(v);
    chk("err_cleared_on_start", a_err, 0);
    send_a(stall_at, stall_len);
    wait_done_a();
  endtask

  function automatic logic [L-1:0] image_a();
    logic [39:0] cat = {words_a[0], words_a[1], words_a[2], words_a[3], words_a[4]};
    return cat[39:4];
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, a_ready, 0);
    chk({tag, "_head"}, a_head, 0);
    chk({tag, "_shift"}, a_shift, 0);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_done"}, a_done, 0);
    chk({tag, "_err"}, a_err, 0);
    chk({tag, "_bc"}, a_bc, 0);
  endtask

  task automatic set_words(input logic [39:0] w);
    for (int i = 0; i < 5; i++) words_a[i] = w[39 - 8*i -: 8];
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int sh0, lo0, d0, g, rdy_after, flipped;
    logic [L-1:0] exp_img;
    repeat (3) tick();
    pReset = 0;
    tick();
    chk_reset_outputs("reset");

    // 1) plain load, no stalls
    set_words(40'hA53CF00F93);
    sh0 = a_sh_cnt; lo0 = a_low_cnt; d0 = a_done_cnt;
    run_a(0, -1, 0);
    chk("t1_chain", chain_a, 36'hA53CF00F9);
    chk("t1_shifts", a_sh_cnt - sh0, 36);
    chk("t1_low_cycles", a_low_cnt - lo0, 1);
    chk("t1_done_pulses", a_done_cnt - d0, 1);
    chk("t1_err", a_err, 0);

    // 2) load plus verify
    sh0 = a_sh_cnt; d0 = a_done_cnt;
    run_a(1, -1, 0);
    chk("t2_chain", chain_a, 36'hA53CF00F9);
    chk("t2_shifts", a_sh_cnt - sh0, 72);
    chk("t2_done_pulses", a_done_cnt - d0, 1);
    chk("t2_err", a_err, 0);

    // 3) corrupt flop 17 between load and verify
    flip_req = 1;
    run_a(1, -1, 0);
    flip_req = 0;
    chk("t3_err_set", a_err, 1);
    repeat (5) tick();
    chk("t3_err_sticky", a_err, 1);

    // 4) source stall of 3 cycles between words 2 and 3
    lo0 = a_low_cnt;
    run_a(0, 2, 3);
    chk("t4_chain", chain_a, 36'hA53CF00F9);
    chk("t4_low_cycles", a_low_cnt - lo0, 4);

    // 5a) start re-pulsed mid-load
    d0 = a_done_cnt; sh0 = a_sh_cnt;
    fork
      run_a(0, -1, 0);
      begin repeat (12) tick(); a_start = 1; tick(); a_start = 0; end
    join
    chk("t5a_chain", chain_a, 36'hA53CF00F9);
    chk("t5a_shifts", a_sh_cnt - sh0, 36);
    chk("t5a_done_pulses", a_done_cnt - d0, 1);

    // 5b) reset at bit_count 20, then a clean reload
    set_words(40'h5AC30FF06C);
    start_a(0);
    fork
      send_a(-1, 0);
      begin
        g = 0;
        while (a_bc != CW'(20) && g < 200) begin tick(); g++; end
        chk("t5b_bc20_timeout", (g >= 200), 0);
        pReset = 1;
        #1;
        chk_reset_outputs("t5b_abort");
      end
    join
    tick(); tick();
    pReset = 0;
    tick();
    run_a(0, -1, 0);
    chk("t5b_chain", chain_a, 36'h5AC30FF06);

    // randomized loads
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < 5; i++) words_a[i] = WA'($urandom);
      exp_img = image_a();
      d0 = a_done_cnt;
      run_a(1'($urandom), $urandom_range(0, 5), $urandom_range(0, 4));
      chk("rnd_chain", chain_a, exp_img);
      chk("rnd_done_pulses", a_done_cnt - d0, 1);
    end

    // 6) 32-bit words: two words, last 28 bits discarded
    sh0 = b_sh_cnt; rdy_after = 0;
    b_start = 1; tick(); b_start = 0;
    b_data = 32'hDEADBEEF; b_valid = 1; g = 0;
    while (!b_ready && g < 100) begin tick(); g++; end
    tick();
    b_data = 32'h12345678; g = 0;
    while (!b_ready && g < 100) begin tick(); g++; end
    tick();
    b_data = 32'hFFFFFFFF; g = 0;
    while (!b_done && g < 200) begin
      if (b_ready) rdy_after++;
      tick(); g++;
    end
    chk("t6_done_timeout", (g >= 200), 0);
    b_valid = 0;
    tick();
    chk("t6_chain", chain_b, 36'hDEADBEEF1);
    chk("t6_shifts", b_sh_cnt - sh0, 36);
    chk("t6_ready_after_w2", rdy_after, 0);
    chk("t6_err", b_err, 0);
    flipped = 0;

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + flipped);
    $finish;
  end

endmodule
